unsigned_product_accumulator: RTL and testbench

Sequential stage directly downstream of `unsigned_multiply`: it consumes the 10-bit unsigned product stream and sums a fixed-length frame of `FRAME_LEN` products into a wider accumulator. The frame result is presented on a valid/ready output port. Saturation is flagged per frame. It turns the combinational multiplier into a dot-product/MAC datapath for post-route equivalence benches.

---
 rtl/unsigned_product_accumulator_if.sv | 38 +++
 rtl/unsigned_product_accumulator.sv | 132 +++++++++++++
 tb/tb_unsigned_product_accumulator.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unsigned_product_accumulator_if.sv
// unsigned_product_accumulator_if
// Groups the product stream, the frame abort and the frame-result handshake
// that connect a product source, the accumulator and a result consumer.
//   product_in / in_valid / in_ready : upstream product handshake
//   clear                            : synchronous frame abort from upstream
//   acc_out / overflow / out_valid /
//   out_ready                        : downstream frame-result handshake
//   count_out                        : products accepted in the current frame
// Modports:
//   master : source/consumer side (drives products, clear, out_ready)
//   slave  : accumulator side (drives in_ready and the frame result)
interface unsigned_product_accumulator_if #(
  parameter int PROD_W = 10,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 3
);

  logic [PROD_W-1:0] product_in;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count_out;

  modport master (
    output product_in, in_valid, clear, out_ready,
    input  in_ready, acc_out, overflow, out_valid, count_out
  );

  modport slave (
    input  product_in, in_valid, clear, out_ready,
    output in_ready, acc_out, overflow, out_valid, count_out
  );

endinterface

// File: rtl/unsigned_product_accumulator.sv
// unsigned_product_accumulator
// Sums fixed-length frames of FRAME_LEN unsigned products into an ACC_W-bit
// saturating accumulator and presents each frame sum on a valid/ready port.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport of unsigned_product_accumulator_if carrying the
//          product handshake, clear, frame result handshake and count_out
// Two-state FSM: ACCUM takes one product per cycle; HOLD presents the frame
// result until the consumer takes it. in_ready has no path from out_ready.
module unsigned_product_accumulator #(
  parameter int PROD_W    = 10,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic                            clk,
  input  logic                            rst,
  unsigned_product_accumulator_if.slave   bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;

  logic               in_ready;
  logic               accept;
  logic [ACC_W:0]     sum;
  logic               sat;
  logic [ACC_W-1:0]   acc_next;
  logic               last_of_frame;

  // in_ready is forced low during reset so nothing is taken on a reset edge
  assign in_ready      = (state_q == ACCUM) && !rst;
  assign accept        = bus.in_valid && in_ready && !bus.clear;
  assign last_of_frame = (count_q == CNT_W'(FRAME_LEN - 1));

  assign bus.in_ready  = in_ready;
  assign bus.acc_out   = acc_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count_out = count_q;

  // Saturating add: the extra top bit of the sum is the carry; once the
  // sticky bit is set the frame stays pinned at all-ones until it completes.
  always_comb begin
    sum      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product_in};
    sat      = sum[ACC_W] || sticky_q;
    acc_next = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // Next-state logic. clear wins over both accept and the output handshake
  // and leaves acc_out alone so the last delivered sum stays visible.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    count_d     = count_q;
    acc_out_d   = acc_out_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    if (bus.clear) begin
      acc_d       = '0;
      sticky_d    = 1'b0;
      count_d     = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last_of_frame) begin
              acc_out_d   = acc_next;
              overflow_d  = sat;
              out_valid_d = 1'b1;
              acc_d       = '0;
              sticky_d    = 1'b0;
              count_d     = '0;
              state_d     = HOLD;
            end else begin
              acc_d       = acc_next;
              sticky_d    = sat;
              count_d     = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
      acc_out_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      acc_out_q   <= acc_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// tb_unsigned_product_accumulator
// Drives identical stimulus into a 16-bit and a 12-bit accumulator instance.
// A frame-level model (running sum, count, holding flag) predicts each frame
// result as min(sum, 2^ACC_W-1) and pushes it into a per-instance queue; a
// monitor pops and compares whenever a result is handed off or discarded.
module tb_unsigned_product_accumulator;

  localparam int PROD_W    = 10;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 3;
  localparam int ACC_A     = 16;
  localparam int ACC_B     = 12;

  typedef struct packed {
    logic        ovf;
    logic [31:0] acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [PROD_W-1:0] product_in;
  logic              in_valid;
  logic              clear;
  logic              out_ready;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   accepted;

  // Frame-level reference state
  bit          holding;
  int unsigned cnt;
  int unsigned frame_sum;
  exp_t        last_a, last_b;
  exp_t        q_a[$];
  exp_t        q_b[$];

  always #5 clk = ~clk;

  unsigned_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_A), .CNT_W(CNT_W)) bus_a ();
  unsigned_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_B), .CNT_W(CNT_W)) bus_b ();

  assign bus_a.product_in = product_in;
  assign bus_a.in_valid   = in_valid;
  assign bus_a.clear      = clear;
  assign bus_a.out_ready  = out_ready;
  assign bus_b.product_in = product_in;
  assign bus_b.in_valid   = in_valid;
  assign bus_b.clear      = clear;
  assign bus_b.out_ready  = out_ready;

  unsigned_product_accumulator #(
    .PROD_W(PROD_W), .ACC_W(ACC_A), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  unsigned_product_accumulator #(
    .PROD_W(PROD_W), .ACC_W(ACC_B), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  function automatic exp_t saturate(input int unsigned s, input int w);
    exp_t        e;
    int unsigned max_val;
    max_val = (32'd1 << w) - 1;
    e.ovf   = (s > max_val);
    e.acc   = (s > max_val) ? max_val : s;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check visible state against the model at
  // the falling edge, then advance the model at the rising edge.
  task automatic applyStimulus(input logic [PROD_W-1:0] p, input logic v,
                               input logic c, input logic ordy, input logic r);
    product_in = p;
    in_valid   = v;
    clear      = c;
    out_ready  = ordy;
    rst        = r;
    accepted   = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_a",  32'(bus_a.in_ready),  32'(!holding && !r));
    checkOutput("in_ready_b",  32'(bus_b.in_ready),  32'(!holding && !r));
    checkOutput("out_valid_a", 32'(bus_a.out_valid), 32'(holding));
    checkOutput("out_valid_b", 32'(bus_b.out_valid), 32'(holding));
    checkOutput("count_a",     32'(bus_a.count_out), cnt);
    checkOutput("count_b",     32'(bus_b.count_out), cnt);
    checkOutput("acc_out_a",   32'(bus_a.acc_out),   last_a.acc);
    checkOutput("acc_out_b",   32'(bus_b.acc_out),   last_b.acc);
    checkOutput("overflow_a",  32'(bus_a.overflow),  32'(holding && last_a.ovf));
    checkOutput("overflow_b",  32'(bus_b.overflow),  32'(holding && last_b.ovf));
    @(posedge clk);
    if (r) begin
      holding   = 1'b0;
      cnt       = 0;
      frame_sum = 0;
      last_a    = '0;
      last_b    = '0;
    end else if (c) begin
      holding   = 1'b0;
      cnt       = 0;
      frame_sum = 0;
    end else if (holding) begin
      if (ordy) holding = 1'b0;
    end else if (v) begin
      accepted  = 1'b1;
      frame_sum = frame_sum + p;
      if (cnt == FRAME_LEN - 1) begin
        last_a    = saturate(frame_sum, ACC_A);
        last_b    = saturate(frame_sum, ACC_B);
        q_a.push_back(last_a);
        q_b.push_back(last_b);
        holding   = 1'b1;
        cnt       = 0;
        frame_sum = 0;
      end else begin
        cnt = cnt + 1;
      end
    end
    #1;
  endtask

  task automatic sendFrame(input int unsigned val, input logic ordy);
    for (int i = 0; i < FRAME_LEN; i++) applyStimulus(PROD_W'(val), 1'b1, 1'b0, ordy, 1'b0);
  endtask

  // Scoreboard monitor: a result leaves the DUT on a handshake (compared) or
  // is thrown away by clear/rst while held (popped without comparing).
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && bus_a.out_valid && (out_ready || clear || rst)) begin
      if (q_a.size() == 0) begin
        checkOutput("sb_a_unexpected", 32'(bus_a.out_valid), 32'd0);
      end else begin
        e = q_a.pop_front();
        if (!clear && !rst) begin
          checkOutput("sb_acc_a", 32'(bus_a.acc_out), e.acc);
          checkOutput("sb_ovf_a", 32'(bus_a.overflow), 32'(e.ovf));
        end
      end
    end
    if (mon_en && bus_b.out_valid && (out_ready || clear || rst)) begin
      if (q_b.size() == 0) begin
        checkOutput("sb_b_unexpected", 32'(bus_b.out_valid), 32'd0);
      end else begin
        e = q_b.pop_front();
        if (!clear && !rst) begin
          checkOutput("sb_acc_b", 32'(bus_b.acc_out), e.acc);
          checkOutput("sb_ovf_b", 32'(bus_b.overflow), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    logic [PROD_W-1:0] p;
    int                tries;
    int unsigned       a, b;

    product_in = '0;
    in_valid   = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    rst        = 1'b1;
    holding    = 1'b0;
    cnt        = 0;
    frame_sum  = 0;
    last_a     = '0;
    last_b     = '0;
    accepted   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    $display("[TB] reset state");
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] 8 x 961, out_ready high");
    sendFrame(961, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] 8 x 1 after a saturated frame");
    sendFrame(1, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] frame 1..8 held for 5 cycles");
    for (int i = 1; i <= FRAME_LEN; i++) applyStimulus(PROD_W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(PROD_W'(99), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] clear mid-frame drops the product");
    for (int i = 0; i < 3; i++) applyStimulus(PROD_W'(100), 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(PROD_W'(100), 1'b1, 1'b1, 1'b1, 1'b0);
    sendFrame(10, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-frame and in hold");
    for (int i = 0; i < 5; i++) applyStimulus(PROD_W'(50), 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(PROD_W'(50), 1'b1, 1'b0, 1'b1, 1'b1);
    sendFrame(7, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(3, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1);
    sendFrame(20, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] random products with gaps, stalls and rare clears");
    for (int n = 0; n < 100; n++) begin
      a = $urandom_range(0, 31);
      b = $urandom_range(0, 31);
      p = PROD_W'(a * b);
      tries = 0;
      do begin
        applyStimulus(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                      $urandom_range(0, 1) != 0, 1'b0);
        tries++;
      end while (!accepted && tries < 60);
      if (!accepted) checkOutput("accept_timeout", 32'(tries), 32'd0);
    end

    for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sb_a_drained", 32'(q_a.size()), 32'd0);
    checkOutput("sb_b_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
